// File: rtl/noc_vchannel_sched.sv
// Credit-based, packet-aware round-robin scheduler: multiplexes CHANNELS virtual
// channels onto one registered NoC link, holding the grant for a whole packet.

module noc_vc_credit #(
    parameter int CREDITS = 4,
    parameter int CW      = $clog2(CREDITS + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic take,
    input  logic give,
    output logic avail
);
    localparam logic [CW-1:0] FULL = CW'(CREDITS);

    logic [CW-1:0] cnt;

    // A return arriving at full credit is dropped so the count never exceeds the buffer depth.
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= FULL;
        else if (take && !give)
            cnt <= cnt - 1'b1;
        else if (give && !take && cnt != FULL)
            cnt <= cnt + 1'b1;
    end

    assign avail = (cnt != '0);
endmodule

module noc_vchannel_sched #(
    parameter int FLIT_WIDTH = 32,
    parameter int CHANNELS   = 2,
    parameter int CREDITS    = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [CHANNELS-1:0][FLIT_WIDTH-1:0] in_flit,
    input  logic [CHANNELS-1:0]                in_last,
    input  logic [CHANNELS-1:0]                in_valid,
    output logic [CHANNELS-1:0]                in_ready,
    output logic [FLIT_WIDTH-1:0]              out_flit,
    output logic                               out_last,
    output logic                               out_valid,
    output logic [CHANNELS-1:0]                out_vc,
    input  logic [CHANNELS-1:0]                credit_in
);
    localparam int PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    typedef struct packed {
        logic [FLIT_WIDTH-1:0] flit;
        logic                  last;
        logic [CHANNELS-1:0]   vc;
        logic                  valid;
    } link_t;

    state_t              state, state_nxt;
    logic [PW-1:0]       rr_ptr, rr_ptr_nxt;
    logic [CHANNELS-1:0] lock_vc, lock_vc_nxt;
    logic [CHANNELS-1:0] avail, eligible, grant, xfer;
    logic [PW-1:0]       grant_idx;
    logic [FLIT_WIDTH-1:0] sel_flit;
    logic                sel_last;
    link_t               link_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_vc
        noc_vc_credit #(.CREDITS(CREDITS)) u_credit (
            .clk   (clk),
            .rst   (rst),
            .take  (xfer[c]),
            .give  (credit_in[c]),
            .avail (avail[c])
        );
    end

    assign eligible = in_valid & avail;

    // First eligible VC at or after the pointer, wrapping.
    always_comb begin
        int  idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < CHANNELS; i++) begin
            idx = (int'(rr_ptr) + i) % CHANNELS;
            if (!found && eligible[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = PW'(idx);
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (!rst)
            in_ready = (state == IDLE) ? grant : (lock_vc & eligible);
    end

    assign xfer = in_ready & in_valid;

    always_comb begin
        sel_flit = '0;
        sel_last = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (xfer[c]) begin
                sel_flit = sel_flit | in_flit[c];
                sel_last = sel_last | in_last[c];
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        rr_ptr_nxt  = rr_ptr;
        lock_vc_nxt = lock_vc;
        case (state)
            IDLE: begin
                if (|xfer) begin
                    rr_ptr_nxt = (grant_idx == PW'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
                    if (!sel_last) begin
                        state_nxt   = LOCKED;
                        lock_vc_nxt = xfer;
                    end
                end
            end
            LOCKED: begin
                if ((|xfer) && sel_last) begin
                    state_nxt   = IDLE;
                    lock_vc_nxt = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            lock_vc <= '0;
        end else begin
            state   <= state_nxt;
            rr_ptr  <= rr_ptr_nxt;
            lock_vc <= lock_vc_nxt;
        end
    end

    // Link register; last/vc are qualified so an idle slot carries no stale tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            link_q <= '0;
        end else begin
            link_q.valid <= |xfer;
            link_q.last  <= sel_last;
            link_q.vc    <= xfer;
            if (|xfer)
                link_q.flit <= sel_flit;
        end
    end

    assign out_flit  = link_q.flit;
    assign out_last  = link_q.last;
    assign out_valid = link_q.valid;
    assign out_vc    = link_q.vc;
endmodule

// File: tb/tb_noc_vchannel_sched.sv
// Directed bench for noc_vchannel_sched (CHANNELS=2, CREDITS=4): arbitration,
// packet lock, credit accounting, output register and reset behaviour.

module tb_noc_vchannel_sched;
    logic             clk;
    logic             rst;
    logic [1:0][31:0] in_flit;
    logic [1:0]       in_last;
    logic [1:0]       in_valid;
    logic [1:0]       in_ready;
    logic [31:0]      out_flit;
    logic             out_last;
    logic             out_valid;
    logic [1:0]       out_vc;
    logic [1:0]       credit_in;

    int checks = 0;
    int errors = 0;

    noc_vchannel_sched #(.FLIT_WIDTH(32), .CHANNELS(2), .CREDITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_flit   (in_flit),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_flit  (out_flit),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_vc    (out_vc),
        .credit_in (credit_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ready_is(input string tag, input logic [1:0] exp);
        #1;
        chk(tag, 32'(in_ready), 32'(exp));
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = '0;
        credit_in = '0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = '0; in_last = '0; in_flit = '0; credit_in = '0;
        ready_is("reset_ready", 2'b00);
        tick();
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_out_last",  32'(out_last),  0);
        chk("reset_out_vc",    32'(out_vc),    0);
        chk("reset_out_flit",  out_flit,       0);
        rst = 1'b0;
        #1;
        chk("post_reset_out_valid", 32'(out_valid), 0);

        // Two single-flit streams alternate 0,1,0,1.
        in_valid = 2'b11; in_last = 2'b11;
        in_flit[0] = 32'hA000_0000; in_flit[1] = 32'hB000_0000;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] e;
            e = (k % 2 == 0) ? 2'b01 : 2'b10;
            ready_is("rr_ready", e);
            tick();
            chk("rr_out_valid", 32'(out_valid), 1);
            chk("rr_out_vc", 32'(out_vc), 32'(e));
            chk("rr_out_flit", out_flit, (k % 2 == 0) ? 32'hA000_0000 : 32'hB000_0000);
        end

        // Three-flit packet on VC0 holds the link while VC1 waits.
        do_reset();
        in_valid = 2'b11; in_last = 2'b10; in_flit[1] = 32'hB100_0000;
        for (int k = 0; k < 3; k++) begin
            in_flit[0] = 32'hC000_0000 + 32'(k);
            in_last[0] = (k == 2);
            ready_is("lock_ready", 2'b01);
            tick();
            chk("lock_out_vc", 32'(out_vc), 1);
            chk("lock_out_last", 32'(out_last), (k == 2) ? 1 : 0);
            chk("lock_out_flit", out_flit, 32'hC000_0000 + 32'(k));
        end
        in_valid = 2'b10;
        ready_is("after_lock_ready", 2'b10);
        tick();
        chk("after_lock_out_vc", 32'(out_vc), 2);
        chk("after_lock_out_flit", out_flit, 32'hB100_0000);

        // Credit exhaustion on VC0, then a single returned credit.
        do_reset();
        in_valid = 2'b01; in_last = 2'b01;
        for (int k = 0; k < 4; k++) begin
            ready_is("drain_ready", 2'b01);
            tick();
        end
        ready_is("empty_ready", 2'b00);
        tick();
        chk("empty_out_valid", 32'(out_valid), 0);
        credit_in = 2'b01;
        ready_is("credit_same_cycle_ready", 2'b00);
        tick();
        credit_in = 2'b00;
        ready_is("credit_next_cycle_ready", 2'b01);
        tick();
        chk("credit_xfer_out_valid", 32'(out_valid), 1);
        ready_is("credit_used_ready", 2'b00);

        // VC1 locked with no credit blocks eligible VC0.
        do_reset();
        in_valid = 2'b10; in_last = 2'b00;
        for (int k = 0; k < 4; k++) begin
            ready_is("vc1_drain_ready", 2'b10);
            tick();
        end
        in_valid = 2'b11; in_last = 2'b01;
        ready_is("stall_ready", 2'b00);
        tick();
        chk("stall_out_valid", 32'(out_valid), 0);
        credit_in = 2'b10;
        ready_is("stall_credit_ready", 2'b00);
        tick();
        credit_in = 2'b00; in_last = 2'b11;
        ready_is("resume_ready", 2'b10);
        tick();
        chk("resume_out_last", 32'(out_last), 1);
        chk("resume_out_vc", 32'(out_vc), 2);
        ready_is("vc0_after_unlock_ready", 2'b01);
        tick();
        chk("vc0_after_unlock_out_vc", 32'(out_vc), 1);

        // Simultaneous take and return leaves the count at 4.
        do_reset();
        in_valid = 2'b01; in_last = 2'b01; credit_in = 2'b01;
        for (int k = 0; k < 6; k++) begin
            ready_is("take_give_ready", 2'b01);
            tick();
        end
        credit_in = 2'b00;
        for (int k = 0; k < 4; k++) begin
            ready_is("take_give_drain_ready", 2'b01);
            tick();
        end
        ready_is("take_give_empty_ready", 2'b00);

        // Returns at full credit saturate.
        do_reset();
        credit_in = 2'b01;
        for (int k = 0; k < 3; k++) tick();
        credit_in = 2'b00; in_valid = 2'b01; in_last = 2'b01;
        for (int k = 0; k < 4; k++) begin
            ready_is("sat_drain_ready", 2'b01);
            tick();
        end
        ready_is("sat_empty_ready", 2'b00);

        // Reset while locked on VC1.
        do_reset();
        in_valid = 2'b10; in_last = 2'b00;
        ready_is("pre_rst_lock_ready", 2'b10);
        tick();
        rst = 1'b1; in_valid = 2'b11; in_last = 2'b11;
        ready_is("rst_cycle_ready", 2'b00);
        tick();
        rst = 1'b0;
        chk("rst_lock_out_valid", 32'(out_valid), 0);
        for (int k = 0; k < 8; k++) begin
            ready_is("post_rst_ready", (k % 2 == 0) ? 2'b01 : 2'b10);
            tick();
        end
        ready_is("post_rst_empty_ready", 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/noc_vchannel_sched.md
# noc_vchannel_sched

Packet-aware, credit-based scheduler that multiplexes `CHANNELS` virtual channels onto one physical NoC link. It sits between the per-VC input buffers and the link register. It arbitrates round-robin among VCs that have both a flit and a downstream credit. It holds the grant for a whole packet (first flit to `last`), and tracks per-VC downstream buffer credits.

## Interface
- `FLIT_WIDTH`, 32, flit payload width
- `CHANNELS`, 2, number of virtual channels (≥2)
- `CREDITS`, 4, initial/maximum credits per VC (downstream buffer depth, ≥1)

- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `in_flit`  in  `[CHANNELS][FLIT_WIDTH]`  per-VC flit
- `in_last`  in  `[CHANNELS]`  flit is last of packet
- `in_valid`  in  `[CHANNELS]`  per-VC flit valid
- `in_ready`  out  `[CHANNELS]`  per-VC accept; at most one bit set
- `out_flit`  out  `FLIT_WIDTH`  registered link flit
- `out_last`  out  1  registered last flag
- `out_valid`  out  1  registered link valid
- `out_vc`  out  `[CHANNELS]`  registered one-hot VC tag of `out_flit`
- `credit_in`  in  `[CHANNELS]`  one-cycle credit-return pulses from downstream

## Operation
- Credit counter per VC, width `$clog2(CREDITS+1)`, reset to `CREDITS`.
  - A transfer on VC c decrements it.
  - `credit_in[c]` increments it.
  - Both in the same cycle: the counter is unchanged.
  - `credit_in[c]` while the counter is `CREDITS` with no transfer: ignored, counter saturates.
- `eligible[c] = in_valid[c] & (credit[c] != 0)`.
- FSM states IDLE and LOCKED; reset state IDLE. `lock_vc` (one-hot) is reset to 0. RR pointer is reset so VC0 has highest priority.
- IDLE:
  - Grant goes to the first eligible VC at or after the pointer, wrapping.
  - `in_ready[grant]=1` and the flit transfers this cycle.
  - If the transferred flit has `in_last=1`: stay IDLE.
  - Otherwise: go to LOCKED with `lock_vc=grant`.
  - Either way the pointer moves to grant+1 (mod `CHANNELS`).
  - No eligible VC: `in_ready=0`, no transfer.
- LOCKED:
  - Only `lock_vc` may transfer, when it is eligible. Other VCs get `in_ready=0` even if eligible.
  - A transfer with `in_last=1` returns the FSM to IDLE and clears `lock_vc`.
  - A stall for lack of credit or valid keeps LOCKED indefinitely.
- Transfer on c ≡ `in_valid[c] & in_ready[c]`. `in_ready[c]` never asserts unless `in_valid[c]` and a credit are present.
- A single-flit packet (`in_last` on the first flit) never enters LOCKED.

## Timing
- `in_ready` is combinational from FSM state, RR pointer, credit registers and `in_valid`.
  - It has no combinational path from `credit_in`: a returned credit becomes usable the next cycle.
- Output register: cycle N transfer → `out_valid=1`, `out_flit`, `out_last`, `out_vc` valid in cycle N+1.
  - No transfer in N → `out_valid=0` in N+1.
- Latency 1 cycle. Throughput 1 flit/cycle while credits last.
- Full rate on one VC needs round-trip credit latency ≤ `CREDITS`.
- Reset values: `out_valid=0`, `out_last=0`, `out_vc=0`, `out_flit=0`. `in_ready=0` during the reset cycle. Credits are `CREDITS`.
- Reset mid-packet: lock is dropped and credits are restored. Upstream and downstream are reset together; packet recovery is not handled.

## Test plan
- Reset, CHANNELS=2, CREDITS=4:
  - VC0 and VC1 each present a 1-flit packet continuously → grants alternate 0,1,0,1.
  - `out_vc` = 01,10,01,10 one cycle after each transfer.
  - `out_valid` is 0 in the first cycle after reset.
- VC0 sends a 3-flit packet while VC1 is valid throughout → three VC0 transfers back-to-back, then VC1.
  - `in_ready[1]=0` during the lock.
  - `out_last=1` only on VC0's third output flit.
- No `credit_in`, VC0 streams 1-flit packets → exactly 4 transfers, then `in_ready[0]=0`.
  - A `credit_in[0]` pulse in cycle N → one transfer in cycle N+1.
- LOCKED on VC1 mid-packet with credit 0 while VC0 is eligible → no transfers at all.
  - `credit_in[1]` → VC1 resumes the next cycle; VC0 is served after VC1's last flit.
- Transfer and `credit_in` on the same VC in the same cycle → counter unchanged.
  - `credit_in` at full credit → counter stays at 4.
- `rst` asserted while LOCKED on VC1 → next cycle state IDLE, credits 4/4, `out_valid=0`.
  - The first post-reset grant goes to VC0 if both VCs are eligible.
